// File: rtl/profile_pkg.sv
// Shared profile-histogram sizing and control-state encoding; used by the
// time-phase calculator, the peak finder and the accumulator.
package profile_pkg;
    localparam int PROF_NBINS = 1024;
    localparam int PROF_AW    = 10;
    localparam int PROF_CW    = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } prof_state_e;
endpackage

// File: rtl/profile_ram.sv
// Bin store: one write port, two enabled synchronous read ports, read-before-write.
// Read data appears the cycle after the enable and holds until the next enable.
module profile_ram
    import profile_pkg::*;
#(
    parameter int NBINS = PROF_NBINS,
    parameter int AW    = PROF_AW,
    parameter int CW    = PROF_CW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [CW-1:0] wdata_i,
    input  logic          re_a_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [CW-1:0] rdata_a_o,
    input  logic          re_b_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [CW-1:0] rdata_b_o
);
    logic [CW-1:0] mem_q [NBINS];

    always_ff @(posedge clk) begin
        if (we_i)   mem_q[waddr_i] <= wdata_i;
        if (re_a_i) rdata_a_o      <= mem_q[raddr_a_i];
        if (re_b_i) rdata_b_o      <= mem_q[raddr_b_i];
    end
endmodule

// File: rtl/profile_accumulator.sv
// Phase-bin histogram: one hit/cycle via 2-stage RMW, readout 1 cycle after rd_req.
// No backpressure; hits during the NBINS-cycle clear sweep are dropped and counted.
module profile_accumulator
    import profile_pkg::*;
#(
    parameter int NBINS = PROF_NBINS,
    parameter int AW    = PROF_AW,
    parameter int CW    = PROF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hit_valid,
    input  logic [AW-1:0] hit_bin,
    input  logic          clear_req,
    output logic          clear_busy,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [CW-1:0] rd_data,
    output logic [CW-1:0] total_hits,
    output logic [15:0]   drop_count,
    output logic          sat_flag
);
    localparam logic [AW:0]   NB_L      = (AW+1)'(NBINS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NBINS - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    prof_state_e   state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          s1_vld_q, s1_vld_d;
    logic [AW-1:0] s1_bin_q, s1_bin_d;
    logic          w_vld_q, w_vld_d;
    logic [AW-1:0] w_bin_q, w_bin_d;
    logic [CW-1:0] w_dat_q, w_dat_d;
    logic [CW-1:0] total_q, total_d;
    logic [15:0]   drop_q, drop_d;
    logic          sat_q, sat_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_zero_q, rd_zero_d;
    logic          rd_fwd_q, rd_fwd_d;
    logic [CW-1:0] rd_fwd_dat_q, rd_fwd_dat_d;

    logic          run, hit_in_rng, rd_in_rng, accept, drop_ev, bin_full;
    logic [CW-1:0] base_cnt, new_cnt, rmw_rdata, rd_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [CW-1:0] ram_wdata;

    assign run        = (state_q == ST_RUN);
    assign hit_in_rng = ({1'b0, hit_bin} < NB_L);
    assign rd_in_rng  = ({1'b0, rd_addr} < NB_L);
    assign accept     = run && !clear_req && hit_valid && hit_in_rng;
    assign drop_ev    = hit_valid && hit_in_rng && (!run || clear_req);

    // The RAM read issued alongside last cycle's write saw the old value.
    assign base_cnt = (w_vld_q && (w_bin_q == s1_bin_q)) ? w_dat_q : rmw_rdata;
    assign bin_full = (base_cnt == CNT_MAX);
    assign new_cnt  = bin_full ? base_cnt : base_cnt + 1'b1;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_bin_q;
        ram_wdata = new_cnt;
        if (!rst) begin
            if (!run) begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdata = '0;
            end else begin
                ram_we = s1_vld_q;
            end
        end
    end

    profile_ram #(.NBINS(NBINS), .AW(AW), .CW(CW)) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .re_a_i    (accept),
        .raddr_a_i (hit_bin),
        .rdata_a_o (rmw_rdata),
        .re_b_i    (rd_req && rd_in_rng && run),
        .raddr_b_i (rd_addr),
        .rdata_b_o (rd_rdata)
    );

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        s1_vld_d     = accept;
        s1_bin_d     = hit_bin;
        w_vld_d      = run && s1_vld_q;
        w_bin_d      = s1_bin_q;
        w_dat_d      = new_cnt;
        total_d      = total_q;
        drop_d       = drop_q;
        sat_d        = sat_q;
        rd_vld_d     = rd_req;
        rd_zero_d    = rd_zero_q;
        rd_fwd_d     = rd_fwd_q;
        rd_fwd_dat_d = rd_fwd_dat_q;

        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end
            end
            default: begin
                if (s1_vld_q && bin_full) sat_d = 1'b1;
                if (accept) begin
                    if (total_q == CNT_MAX) sat_d   = 1'b1;
                    else                    total_d = total_q + 1'b1;
                end
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    total_d = '0;
                    sat_d   = 1'b0;
                end
            end
        endcase

        if (drop_ev && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

        // Read registers only move on a request so rd_data holds between reads.
        if (rd_req) begin
            rd_zero_d    = !run || !rd_in_rng;
            rd_fwd_d     = run && s1_vld_q && (s1_bin_q == rd_addr);
            rd_fwd_dat_d = new_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            s1_vld_q     <= 1'b0;
            s1_bin_q     <= '0;
            w_vld_q      <= 1'b0;
            w_bin_q      <= '0;
            w_dat_q      <= '0;
            total_q      <= '0;
            drop_q       <= '0;
            sat_q        <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_zero_q    <= 1'b1;
            rd_fwd_q     <= 1'b0;
            rd_fwd_dat_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            s1_vld_q     <= s1_vld_d;
            s1_bin_q     <= s1_bin_d;
            w_vld_q      <= w_vld_d;
            w_bin_q      <= w_bin_d;
            w_dat_q      <= w_dat_d;
            total_q      <= total_d;
            drop_q       <= drop_d;
            sat_q        <= sat_d;
            rd_vld_q     <= rd_vld_d;
            rd_zero_q    <= rd_zero_d;
            rd_fwd_q     <= rd_fwd_d;
            rd_fwd_dat_q <= rd_fwd_dat_d;
        end
    end

    assign clear_busy = !run;
    assign rd_valid   = rd_vld_q;
    assign rd_data    = rd_zero_q ? '0 : (rd_fwd_q ? rd_fwd_dat_q : rd_rdata);
    assign total_hits = total_q;
    assign drop_count = drop_q;
    assign sat_flag   = sat_q;
endmodule

// File: tb/tb_profile_accumulator.sv
// Two accumulators (default build, and 1000 bins x 4-bit) share one stimulus
// stream; each is compared against a per-bin array model of the histogram.
module tb_profile_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hit_valid = 1'b0;
    logic [9:0] hit_bin = '0;
    logic       clear_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [9:0] rd_addr = '0;

    logic        busy_a, rdv_a, sat_a, busy_b, rdv_b, sat_b;
    logic [31:0] rdd_a, tot_a;
    logic [3:0]  rdd_b, tot_b;
    logic [15:0] drop_a, drop_b;

    always #5 clk = ~clk;

    profile_accumulator dut_a (
        .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_bin(hit_bin),
        .clear_req(clear_req), .clear_busy(busy_a), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rdv_a), .rd_data(rdd_a), .total_hits(tot_a), .drop_count(drop_a),
        .sat_flag(sat_a)
    );

    profile_accumulator #(.NBINS(1000), .AW(10), .CW(4)) dut_b (
        .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_bin(hit_bin),
        .clear_req(clear_req), .clear_busy(busy_b), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rdv_b), .rd_data(rdd_b), .total_hits(tot_b), .drop_count(drop_b),
        .sat_flag(sat_b)
    );

    logic [63:0] obs_rdd [2];
    logic [63:0] obs_tot [2];
    logic [63:0] obs_drop [2];
    logic        obs_rdv [2];
    logic        obs_sat [2];
    logic        obs_busy [2];
    assign obs_rdd[0]  = 64'(rdd_a);   assign obs_rdd[1]  = 64'(rdd_b);
    assign obs_tot[0]  = 64'(tot_a);   assign obs_tot[1]  = 64'(tot_b);
    assign obs_drop[0] = 64'(drop_a);  assign obs_drop[1] = 64'(drop_b);
    assign obs_rdv[0]  = rdv_a;        assign obs_rdv[1]  = rdv_b;
    assign obs_sat[0]  = sat_a;        assign obs_sat[1]  = sat_b;
    assign obs_busy[0] = busy_a;       assign obs_busy[1] = busy_b;

    // Reference histogram, one per build.
    int          nb_m [2] = '{1024, 1000};
    longint      max_m [2] = '{64'hFFFF_FFFF, 64'hF};
    string       pfx [2] = '{"a.", "b."};
    longint      bins_m [2][1024];
    longint      total_m [2];
    longint      drops_m [2];
    bit          sat_m [2];
    int          left_m [2];
    longint      exp_rd [2];
    bit          exp_rv [2];
    bit          hit_last [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 1024; b++) bins_m[i][b] = 0;
            total_m[i] = 0; drops_m[i] = 0; sat_m[i] = 0;
            left_m[i] = nb_m[i]; exp_rd[i] = 0; exp_rv[i] = 0; hit_last[i] = 0;
        end
    endtask

    task automatic model_step(input bit hv, input int hb, input bit cr, input bit rr, input int ra);
        for (int i = 0; i < 2; i++) begin
            bit busy;
            bit in_rng;
            busy   = (left_m[i] != 0);
            in_rng = (hb < nb_m[i]);
            exp_rv[i]   = rr;
            hit_last[i] = 0;
            if (rr) exp_rd[i] = (busy || ra >= nb_m[i]) ? 0 : bins_m[i][ra];
            if (busy) begin
                if (hv && in_rng && drops_m[i] != 16'hFFFF) drops_m[i]++;
                left_m[i]--;
            end else if (cr) begin
                if (hv && in_rng && drops_m[i] != 16'hFFFF) drops_m[i]++;
                for (int b = 0; b < 1024; b++) bins_m[i][b] = 0;
                total_m[i] = 0; sat_m[i] = 0; left_m[i] = nb_m[i];
            end else if (hv && in_rng) begin
                hit_last[i] = 1;
                if (bins_m[i][hb] == max_m[i]) sat_m[i] = 1; else bins_m[i][hb]++;
                if (total_m[i] == max_m[i])    sat_m[i] = 1; else total_m[i]++;
            end
        end
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic cyc(input bit hv, input int hb, input bit cr, input bit rr, input int ra);
        hit_valid = hv; hit_bin = 10'(hb); clear_req = cr; rd_req = rr; rd_addr = 10'(ra);
        for (int i = 0; i < 2; i++) chk({pfx[i], "clear_busy"}, 64'(obs_busy[i]), 64'(left_m[i] != 0));
        @(posedge clk);
        #1;
        hit_valid = 0; clear_req = 0; rd_req = 0;
        model_step(hv, hb, cr, rr, ra);
        for (int i = 0; i < 2; i++) begin
            chk({pfx[i], "rd_valid"}, 64'(obs_rdv[i]), 64'(exp_rv[i]));
            chk({pfx[i], "rd_data"}, obs_rdd[i], exp_rd[i]);
            chk({pfx[i], "total_hits"}, obs_tot[i], total_m[i]);
            chk({pfx[i], "drop_count"}, obs_drop[i], drops_m[i]);
            // A bin saturation shows one cycle after its hit.
            if (!hit_last[i]) chk({pfx[i], "sat_flag"}, 64'(obs_sat[i]), 64'(sat_m[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1; hit_valid = 0; clear_req = 0; rd_req = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk({pfx[i], "rst.rd_valid"}, 64'(obs_rdv[i]), 0);
            chk({pfx[i], "rst.rd_data"}, obs_rdd[i], 0);
            chk({pfx[i], "rst.total"}, obs_tot[i], 0);
            chk({pfx[i], "rst.drop"}, obs_drop[i], 0);
            chk({pfx[i], "rst.sat"}, 64'(obs_sat[i]), 0);
            chk({pfx[i], "rst.busy"}, 64'(obs_busy[i]), 1);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic count_busy(output int na, output int nb);
        na = 0; nb = 0;
        for (int g = 0; g < 5000 && (busy_a || busy_b); g++) begin
            na += int'(busy_a);
            nb += int'(busy_b);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    int na, nb;

    initial begin
        model_reset();
        do_reset();
        count_busy(na, nb);
        chk("a.busy_len_reset", na, 1024);
        chk("b.busy_len_reset", nb, 1000);
        cyc(0, 0, 0, 1, 5);
        chk("a.bin5_after_sweep", rdd_a, 0);

        for (int k = 0; k < 10; k++) cyc(1, 7, 0, 0, 0);
        cyc(0, 0, 0, 1, 7);
        chk("a.bin7_ten_hits", rdd_a, 10);
        chk("a.total_ten_hits", tot_a, 10);

        for (int k = 0; k < 8; k++) cyc(1, (k % 2 == 0) ? 3 : 4, 0, 0, 0);
        cyc(0, 0, 0, 1, 3);
        chk("a.bin3_alt", rdd_a, 4);
        cyc(0, 0, 0, 1, 4);
        chk("a.bin4_alt", rdd_a, 4);
        cyc(0, 0, 0, 1, 5);
        chk("a.bin5_alt", rdd_a, 0);

        cyc(0, 0, 1, 0, 0);
        na = 0; nb = 0;
        for (int g = 0; g < 5000 && (busy_a || busy_b); g++) begin
            na += int'(busy_a);
            nb += int'(busy_b);
            cyc((g % 10 == 0) && g >= 10 && g <= 50, 20 + g, g == 300, 0, 0);
        end
        chk("a.busy_len_clear", na, 1024);
        chk("b.busy_len_clear", nb, 1000);
        chk("a.drop_five", drop_a, 5);
        chk("b.drop_five", drop_b, 5);
        foreach (nb_m[j]) begin
            int addrs [4] = '{3, 4, 7, 30};
            cyc(0, 0, 0, 1, addrs[j * 2]);
            chk("a.bin_zero_after_clear", rdd_a, 0);
            cyc(0, 0, 0, 1, addrs[j * 2 + 1]);
            chk("b.bin_zero_after_clear", rdd_b, 0);
        end

        for (int k = 0; k < 14; k++) cyc(1, 9, 0, 0, 0);
        cyc(0, 0, 0, 1, 9);
        chk("b.bin9_fourteen", rdd_b, 14);
        chk("b.sat_before", sat_b, 0);
        for (int k = 0; k < 3; k++) cyc(1, 9, 0, 0, 0);
        cyc(0, 0, 0, 1, 9);
        chk("b.bin9_saturated", rdd_b, 15);
        chk("b.sat_after", sat_b, 1);
        chk("a.bin9_seventeen", rdd_a, 17);
        chk("a.sat_after", sat_a, 0);

        cyc(1, 1000, 0, 1, 1005);
        cyc(0, 0, 0, 1, 1000);
        chk("a.bin1000", rdd_a, 1);
        chk("b.bin1000_oob", rdd_b, 0);

        cyc(0, 0, 1, 0, 0);
        repeat (500) cyc(0, 0, 0, 0, 0);
        do_reset();
        count_busy(na, nb);
        chk("a.busy_len_midsweep_rst", na, 1024);
        chk("b.busy_len_midsweep_rst", nb, 1000);

        for (int k = 0; k < 4000; k++) begin
            bit hv, cr, rr;
            int hb, ra;
            hv = ($urandom_range(0, 3) != 0);
            hb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 7));
            cr = ($urandom_range(0, 599) == 0);
            rr = ($urandom_range(0, 2) == 0);
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 7));
            if (k == 2000) begin
                for (int b = 0; b < 3; b++) cyc(1, 2, 0, 0, 0);
                do_reset();
            end
            cyc(hv, hb, cr, rr, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
